// File: rtl/fd_pipe_reg_pkg.sv
// Shared constants and types for the F/D pipeline register of the 5-stage MIPS core.
// Holds the nop encoding, exception codes and the fetch address check.
package fd_pipe_reg_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [4:0]  EXC_NONE     = 5'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        bd;
  } d_stage_t;

  // limit is one past the last legal byte address; 33 bits so base+size cannot overflow
  function automatic logic fetch_fault(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input logic [32:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
  endfunction

endpackage

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register with stall/flush, delay-slot flag, PC+8 link and saturating counters.
// Optional fetch address-error checking is enabled by defining FD_EXC_EN.
module fd_pipe_reg
  import fd_pipe_reg_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
  parameter int          IMEM_WORDS = 4096,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      f_pc,
  input  logic [31:0]      f_instr,
  input  logic             d_is_jump,
  output logic [31:0]      d_pc,
  output logic [31:0]      d_instr,
  output logic [31:0]      d_pc8,
  output logic             d_valid,
  output logic             d_bd,
  output logic [CNT_W-1:0] stall_cnt,
`ifdef FD_EXC_EN
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [4:0]       d_exccode
`else
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  if (IMEM_WORDS < 1 || PC_RESET[1:0] != 2'b00) begin : g_bad_cfg
    $error("fd_pipe_reg: IMEM_WORDS must be positive and PC_RESET word aligned");
  end

  d_stage_t d_q;
  logic     load_fault;

`ifdef FD_EXC_EN
  localparam logic [32:0] IMEM_END = {1'b0, PC_RESET} + (33'(IMEM_WORDS) << 2);

  assign load_fault = fetch_fault(f_pc, PC_RESET, IMEM_END);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      d_exccode <= EXC_NONE;
    end else if (!stall) begin
      d_exccode <= load_fault ? EXC_ADEL : EXC_NONE;
    end
  end
`else
  assign load_fault = 1'b0;
`endif

  // A faulting fetch still occupies the slot (valid) so the exception travels down the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= '{pc: PC_RESET, instr: NOP, valid: 1'b0, bd: 1'b0};
    end else if (flush) begin
      d_q <= '{pc: f_pc, instr: NOP, valid: 1'b0, bd: 1'b0};
    end else if (!stall) begin
      d_q.pc    <= f_pc;
      d_q.instr <= load_fault ? NOP : f_instr;
      d_q.valid <= 1'b1;
      d_q.bd    <= d_is_jump & d_q.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && !flush && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (flush && !(&bubble_cnt)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

  assign d_pc    = d_q.pc;
  assign d_instr = d_q.instr;
  assign d_valid = d_q.valid;
  assign d_bd    = d_q.bd;
  assign d_pc8   = d_q.pc + 32'd8;

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed table-driven bench for fd_pipe_reg; a second instance with CNT_W=4 covers saturation.
// Works in both the default build and with FD_EXC_EN defined.
module tb_fd_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, d_is_jump;
  logic [31:0] f_pc, f_instr;

  logic [31:0] d_pc, d_instr, d_pc8;
  logic        d_valid, d_bd;
  logic [31:0] stall_cnt, bubble_cnt;

  logic [31:0] d4_pc, d4_instr, d4_pc8;
  logic        d4_valid, d4_bd;
  logic [3:0]  stall_cnt4, bubble_cnt4;

`ifdef FD_EXC_EN
  logic [4:0] d_exccode, d4_exccode;
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  fd_pipe_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .f_pc(f_pc), .f_instr(f_instr), .d_is_jump(d_is_jump),
    .d_pc(d_pc), .d_instr(d_instr), .d_pc8(d_pc8), .d_valid(d_valid), .d_bd(d_bd),
    .stall_cnt(stall_cnt),
`ifdef FD_EXC_EN
    .bubble_cnt(bubble_cnt), .d_exccode(d_exccode)
`else
    .bubble_cnt(bubble_cnt)
`endif
  );

  fd_pipe_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .f_pc(f_pc), .f_instr(f_instr), .d_is_jump(d_is_jump),
    .d_pc(d4_pc), .d_instr(d4_instr), .d_pc8(d4_pc8), .d_valid(d4_valid), .d_bd(d4_bd),
    .stall_cnt(stall_cnt4),
`ifdef FD_EXC_EN
    .bubble_cnt(bubble_cnt4), .d_exccode(d4_exccode)
`else
    .bubble_cnt(bubble_cnt4)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  typedef struct {
    logic        st, fl, jmp;
    logic [31:0] pc, instr;
    logic [31:0] e_pc, e_instr, e_pc8;
    logic        e_valid, e_bd;
    logic [31:0] e_sc, e_bc;
    logic [4:0]  e_exc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic fl,
                       input logic [31:0] pc, input logic [31:0] instr, input logic jmp);
    @(negedge clk);
    reset = r; stall = st; flush = fl; f_pc = pc; f_instr = instr; d_is_jump = jmp;
    @(posedge clk);
    #1;
  endtask

  task automatic check_d(input string tag, input vec_t v);
    chk({tag, " d_pc"},       d_pc,       v.e_pc);
    chk({tag, " d_instr"},    d_instr,    v.e_instr);
    chk({tag, " d_pc8"},      d_pc8,      v.e_pc8);
    chk({tag, " d_valid"},    32'(d_valid), 32'(v.e_valid));
    chk({tag, " d_bd"},       32'(d_bd),    32'(v.e_bd));
    chk({tag, " stall_cnt"},  stall_cnt,  v.e_sc);
    chk({tag, " bubble_cnt"}, bubble_cnt, v.e_bc);
`ifdef FD_EXC_EN
    chk({tag, " d_exccode"},  32'(d_exccode), 32'(v.e_exc));
`endif
  endtask

  function automatic vec_t mk(input logic st, fl, jmp, input logic [31:0] pc, instr,
                              input logic [31:0] e_pc, e_instr, input logic e_valid, e_bd,
                              input logic [31:0] e_sc, e_bc, input logic [4:0] e_exc);
    vec_t v;
    v.st = st; v.fl = fl; v.jmp = jmp; v.pc = pc; v.instr = instr;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc8 = e_pc + 32'd8;
    v.e_valid = e_valid; v.e_bd = e_bd; v.e_sc = e_sc; v.e_bc = e_bc; v.e_exc = e_exc;
    return v;
  endfunction

  initial begin
    vec_t        v;
    logic [31:0] base_sc, base_bc;

    // st fl jmp  f_pc         f_instr        exp pc       exp instr     vld bd  sc  bc  exc
    vecs.push_back(mk(0, 0, 0, 32'h3004, 32'h3c01_1234, 32'h3004, 32'h3c01_1234, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h3008, 32'h1111_1111, 32'h3004, 32'h3c01_1234, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h300c, 32'h2222_2222, 32'h3004, 32'h3c01_1234, 1, 0, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h3010, 32'h3333_3333, 32'h3004, 32'h3c01_1234, 1, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h3008, 32'h1022_0003, 32'h3008, 32'h1022_0003, 1, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h3010, 32'h2442_0001, 32'h3010, 32'h2442_0001, 1, 1, 3, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h3014, 32'h5555_5555, 32'h3014, 32'h0,          0, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h3018, 32'h8c22_0000, 32'h3018, 32'h8c22_0000, 1, 0, 3, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h3020, 32'h6666_6666, 32'h3020, 32'h0,          0, 0, 3, 2, 0));
    vecs.push_back(mk(1, 0, 0, 32'h3024, 32'h7777_7777, 32'h3020, 32'h0,          0, 0, 4, 2, 0));
`ifdef FD_EXC_EN
    vecs.push_back(mk(0, 0, 0, 32'h3002, 32'haaaa_0000, 32'h3002, 32'h0,          1, 0, 4, 2, 4));
    vecs.push_back(mk(1, 0, 0, 32'h3100, 32'hbbbb_0000, 32'h3002, 32'h0,          1, 0, 5, 2, 4));
    vecs.push_back(mk(0, 0, 1, 32'h7000, 32'h0000_0011, 32'h7000, 32'h0,          1, 1, 5, 2, 4));
    vecs.push_back(mk(0, 0, 0, 32'h6ffc, 32'h2222_2222, 32'h6ffc, 32'h2222_2222, 1, 0, 5, 2, 0));
    vecs.push_back(mk(0, 0, 0, 32'h2ffc, 32'h0000_0033, 32'h2ffc, 32'h0,          1, 0, 5, 2, 4));
    vecs.push_back(mk(0, 1, 0, 32'h3008, 32'h0000_0044, 32'h3008, 32'h0,          0, 0, 5, 3, 0));
    vecs.push_back(mk(0, 0, 0, 32'h3008, 32'h4444_4444, 32'h3008, 32'h4444_4444, 1, 0, 5, 3, 0));
`endif

    reset = 1'b1; stall = 1'b0; flush = 1'b0; d_is_jump = 1'b0;
    f_pc = 32'h0; f_instr = 32'h0;
    drive(1, 0, 0, 32'h0, 32'h0, 0);
    drive(1, 0, 0, 32'h0, 32'h0, 0);
    check_d("reset", mk(0, 0, 0, 0, 0, 32'h3000, 32'h0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(0, vecs[i].st, vecs[i].fl, vecs[i].pc, vecs[i].instr, vecs[i].jmp);
      check_d($sformatf("vec%0d", i), vecs[i]);
    end
    base_sc = vecs[vecs.size()-1].e_sc;
    base_bc = vecs[vecs.size()-1].e_bc;

    // PC+8 wraps at the top of the address space; that address is also out of imem range
    drive(0, 0, 0, 32'hffff_fffc, 32'h1234_5678, 0);
    v = mk(0, 0, 0, 0, 0, 32'hffff_fffc, EXC ? 32'h0 : 32'h1234_5678, 1, 0,
           base_sc, base_bc, EXC ? 5'd4 : 5'd0);
    v.e_pc8 = 32'h0000_0004;
    check_d("wrap", v);

    // 20 stalled cycles: the 4-bit counter must pin at 4'hF and D must hold throughout
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 32'h3000 + 32'(i) * 4, 32'h9999_0000, 1);
    v.e_sc = base_sc + 20;
    check_d("long_stall", v);
    chk("sat stall_cnt4", 32'(stall_cnt4), 32'hf);
    chk("sat bubble_cnt4", 32'(bubble_cnt4), base_bc);
    chk("sat d4_pc", d4_pc, 32'hffff_fffc);
    drive(0, 1, 0, 32'h3000, 32'h0, 0);
    chk("sat hold stall_cnt4", 32'(stall_cnt4), 32'hf);
    chk("sat main stall_cnt", stall_cnt, base_sc + 21);

    // reset wins over a simultaneous flush and stall in the same edge
    drive(1, 1, 1, 32'h3040, 32'h8888_8888, 1);
    check_d("reset_mid", mk(0, 0, 0, 0, 0, 32'h3000, 32'h0, 0, 0, 0, 0, 0));
    chk("reset_mid stall_cnt4", 32'(stall_cnt4), 32'h0);
    chk("reset_mid bubble_cnt4", 32'(bubble_cnt4), 32'h0);

    // first load after reset: the bubble in D must not flag a delay slot
    drive(0, 0, 0, 32'h3000, 32'h0c00_0c04, 1);
    check_d("post_reset", mk(0, 0, 0, 0, 0, 32'h3000, 32'h0c00_0c04, 1, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
